vram_fill: RTL and testbench



---
 rtl/vram_pkg.sv | 14 +
 rtl/rect_clip.sv | 29 ++
 rtl/vram_fill.sv | 133 +++++++++++++
 tb/tb_vram_fill.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// Shared types and framebuffer geometry defaults for the rectangle-fill engine.
package vram_pkg;
   localparam int          DEF_FB_WIDTH  = 160;
   localparam int          DEF_FB_HEIGHT = 120;
   localparam logic [15:0] DEF_FB_BASE   = 16'h0000;

   typedef logic [11:0] color_t;

   typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} fill_state_t;

   function automatic logic [15:0] pack_pixel(color_t c);
      return {4'h0, c};
   endfunction
endpackage

// File: rtl/rect_clip.sv
// Clips a rectangle against the framebuffer: exclusive end coordinates plus an empty flag.
module rect_clip
   import vram_pkg::*;
#(
   parameter int FB_WIDTH  = DEF_FB_WIDTH,
   parameter int FB_HEIGHT = DEF_FB_HEIGHT
) (
   input  logic [7:0] x0_i,
   input  logic [6:0] y0_i,
   input  logic [7:0] w_i,
   input  logic [6:0] h_i,
   output logic [8:0] x_end_o,
   output logic [7:0] y_end_o,
   output logic       empty_o
);
   localparam logic [8:0] XLIM = 9'(FB_WIDTH);
   localparam logic [7:0] YLIM = 8'(FB_HEIGHT);

   // One extra bit so x0+w / y0+h never wrap before the clamp.
   logic [8:0] x_sum;
   logic [7:0] y_sum;

   assign x_sum   = {1'b0, x0_i} + {1'b0, w_i};
   assign y_sum   = {1'b0, y0_i} + {1'b0, h_i};
   assign x_end_o = (x_sum > XLIM) ? XLIM : x_sum;
   assign y_end_o = (y_sum > YLIM) ? YLIM : y_sum;
   assign empty_o = (w_i == 8'd0) || (h_i == 7'd0) ||
                    ({1'b0, x0_i} >= XLIM) || ({1'b0, y0_i} >= YLIM);
endmodule

// File: rtl/vram_fill.sv
// Solid-colour rectangle fill into the framebuffer; one clipped word write per unstalled cycle.
module vram_fill
   import vram_pkg::*;
#(
   parameter int          FB_WIDTH  = DEF_FB_WIDTH,
   parameter int          FB_HEIGHT = DEF_FB_HEIGHT,
   parameter logic [15:0] FB_BASE   = DEF_FB_BASE
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [7:0]  cmd_x0,
   input  logic [6:0]  cmd_y0,
   input  logic [7:0]  cmd_w,
   input  logic [6:0]  cmd_h,
   input  logic [11:0] cmd_color,
   input  logic        hold,
   output logic [15:0] address_ram,
   output logic [15:0] data_ram,
   output logic        wren_ram,
   output logic        busy,
   output logic        done
);
   localparam logic [15:0] ROW_STRIDE = 16'(FB_WIDTH);

   fill_state_t state_q, state_d;
   logic [7:0]  x0_q, x0_d, w_q, w_d, x_q, x_d;
   logic [6:0]  y0_q, y0_d, h_q, h_d, y_q, y_d;
   color_t      color_q, color_d;
   logic [8:0]  x_end_q, x_end_d;
   logic [7:0]  y_end_q, y_end_d;
   logic [15:0] row_base_q, row_base_d;

   logic [8:0]  clip_x_end;
   logic [7:0]  clip_y_end;
   logic        clip_empty;
   logic        x_last, y_last;

   rect_clip #(.FB_WIDTH(FB_WIDTH), .FB_HEIGHT(FB_HEIGHT)) u_clip (
      .x0_i    (x0_q),
      .y0_i    (y0_q),
      .w_i     (w_q),
      .h_i     (h_q),
      .x_end_o (clip_x_end),
      .y_end_o (clip_y_end),
      .empty_o (clip_empty)
   );

   // Ends are only compared in FILL, where the rectangle is known non-empty (ends >= 1).
   assign x_last = ({1'b0, x_q} == (x_end_q - 9'd1));
   assign y_last = ({1'b0, y_q} == (y_end_q - 8'd1));

   always_comb begin
      state_d    = state_q;
      x0_d       = x0_q;
      y0_d       = y0_q;
      w_d        = w_q;
      h_d        = h_q;
      color_d    = color_q;
      x_d        = x_q;
      y_d        = y_q;
      x_end_d    = x_end_q;
      y_end_d    = y_end_q;
      row_base_d = row_base_q;
      case (state_q)
         IDLE: if (cmd_valid) begin
            x0_d    = cmd_x0;
            y0_d    = cmd_y0;
            w_d     = cmd_w;
            h_d     = cmd_h;
            color_d = cmd_color;
            state_d = SETUP;
         end
         SETUP: begin
            x_d        = x0_q;
            y_d        = y0_q;
            x_end_d    = clip_x_end;
            y_end_d    = clip_y_end;
            row_base_d = FB_BASE + ({9'd0, y0_q} * ROW_STRIDE);
            state_d    = clip_empty ? DONE : FILL;
         end
         FILL: if (!hold) begin
            if (x_last) begin
               x_d        = x0_q;
               y_d        = y_q + 7'd1;
               row_base_d = row_base_q + ROW_STRIDE;
               if (y_last) state_d = DONE;
            end else begin
               x_d = x_q + 8'd1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         x0_q       <= '0;
         y0_q       <= '0;
         w_q        <= '0;
         h_q        <= '0;
         color_q    <= '0;
         x_q        <= '0;
         y_q        <= '0;
         x_end_q    <= '0;
         y_end_q    <= '0;
         row_base_q <= '0;
      end else begin
         state_q    <= state_d;
         x0_q       <= x0_d;
         y0_q       <= y0_d;
         w_q        <= w_d;
         h_q        <= h_d;
         color_q    <= color_d;
         x_q        <= x_d;
         y_q        <= y_d;
         x_end_q    <= x_end_d;
         y_end_q    <= y_end_d;
         row_base_q <= row_base_d;
      end
   end

   // Outputs decode straight from state so an async reset kills wren_ram immediately.
   assign cmd_ready   = (state_q == IDLE);
   assign busy        = (state_q != IDLE);
   assign done        = (state_q == DONE);
   assign wren_ram    = (state_q == FILL) && !hold;
   assign address_ram = (state_q == FILL) ? (row_base_q + {8'd0, x_q}) : 16'd0;
   assign data_ram    = (state_q == FILL) ? pack_pixel(color_q) : 16'd0;
endmodule

// File: tb/tb_vram_fill.sv
// Bench for vram_fill: directed table, reset abort, and random commands against a pixel-list model.
module tb_vram_fill;
   logic        clock, reset_n, cmd_valid, cmd_ready, hold, wren_ram, busy, done;
   logic [7:0]  cmd_x0, cmd_w;
   logic [6:0]  cmd_y0, cmd_h;
   logic [11:0] cmd_color;
   logic [15:0] address_ram, data_ram;

   int n_tests = 0;
   int n_fail  = 0;

   vram_fill dut (
      .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
      .hold(hold), .address_ram(address_ram), .data_ram(data_ram), .wren_ram(wren_ram),
      .busy(busy), .done(done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [7:0]  x0;
      logic [6:0]  y0;
      logic [7:0]  w;
      logic [6:0]  h;
      logic [11:0] color;
      logic [31:0] hold_mask;
      bit          rnd_hold;
      bit          keep;
      int          exp_n;
      int          exp_first;
      int          exp_last;
      int          exp_done;
   } vec_t;

   vec_t tbl[7];

   task automatic chk(input string nm, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Expected writes are simply the list of in-bounds pixels in raster order.
   task automatic run_cmd(input vec_t v, output int nwr, output int first_a,
                          output int last_a, output int done_cyc);
      int pix[$];
      int pos;
      bit done_seen;
      int xe, ye;
      xe = (int'(v.x0) + int'(v.w) > 160) ? 160 : int'(v.x0) + int'(v.w);
      ye = (int'(v.y0) + int'(v.h) > 120) ? 120 : int'(v.y0) + int'(v.h);
      for (int y = int'(v.y0); y < ye; y++)
         for (int x = int'(v.x0); x < xe; x++)
            pix.push_back(y * 160 + x);
      cmd_x0 = v.x0; cmd_y0 = v.y0; cmd_w = v.w; cmd_h = v.h; cmd_color = v.color;
      cmd_valid = 1'b1;
      @(posedge clock); #1;
      if (v.keep) begin
         cmd_x0 = 8'd50; cmd_y0 = 7'd50; cmd_w = 8'd3; cmd_h = 7'd3; cmd_color = 12'h555;
      end else cmd_valid = 1'b0;
      pos = 0; done_seen = 0; nwr = 0; first_a = 0; last_a = 0; done_cyc = -1;
      for (int cyc = 1; cyc < 400; cyc++) begin
         if (v.rnd_hold) hold = ($urandom_range(0, 3) == 0);
         else            hold = (cyc < 32) ? v.hold_mask[cyc] : 1'b0;
         if (done_seen) cmd_valid = 1'b0;
         @(negedge clock);
         if (wren_ram) begin
            if (nwr == 0) first_a = int'(address_ram);
            last_a = int'(address_ram);
            nwr++;
         end
         if (done && done_cyc < 0) done_cyc = cyc;
         if (cyc == 1) begin
            chk("setup_busy", int'(busy), 1);
            chk("setup_ready", int'(cmd_ready), 0);
            chk("setup_wren", int'(wren_ram), 0);
            chk("setup_addr", int'(address_ram), 0);
         end else if (done_seen) begin
            chk("idle_ready", int'(cmd_ready), 1);
            chk("idle_busy", int'(busy), 0);
            chk("idle_done", int'(done), 0);
            break;
         end else if (pos < pix.size()) begin
            chk("fill_wren", int'(wren_ram), hold ? 0 : 1);
            chk("fill_addr", int'(address_ram), pix[pos]);
            chk("fill_data", int'(data_ram), int'(v.color));
            chk("fill_done", int'(done), 0);
            chk("fill_ready", int'(cmd_ready), 0);
            if (!hold) pos++;
         end else begin
            chk("done_pulse", int'(done), 1);
            chk("done_wren", int'(wren_ram), 0);
            chk("done_addr", int'(address_ram), 0);
            chk("done_data", int'(data_ram), 0);
            done_seen = 1;
         end
         @(posedge clock); #1;
      end
      hold = 1'b0;
      cmd_valid = 1'b0;
   endtask

   task automatic run_tbl(input vec_t v, input string nm);
      int nwr, fa, la, dc;
      run_cmd(v, nwr, fa, la, dc);
      chk({nm, "_nwrites"}, nwr, v.exp_n);
      chk({nm, "_first"}, fa, v.exp_first);
      chk({nm, "_last"}, la, v.exp_last);
      chk({nm, "_donecyc"}, dc, v.exp_done);
   endtask

   initial begin
      vec_t rv;
      int nwr, fa, la, dc;
      tbl[0] = '{8'd2,   7'd1,   8'd2, 7'd2, 12'hF00, 32'h0,   0, 0, 4, 162,   323,   6};
      tbl[1] = '{8'd158, 7'd119, 8'd5, 7'd4, 12'h0F0, 32'h0,   0, 0, 2, 19198, 19199, 4};
      tbl[2] = '{8'd10,  7'd10,  8'd0, 7'd3, 12'h123, 32'h0,   0, 0, 0, 0,     0,     2};
      tbl[3] = '{8'd200, 7'd5,   8'd4, 7'd4, 12'h456, 32'h0,   0, 0, 0, 0,     0,     2};
      tbl[4] = '{8'd2,   7'd1,   8'd2, 7'd2, 12'hF00, 32'h11A, 0, 0, 4, 162,   323,   8};
      tbl[5] = '{8'd5,   7'd5,   8'd3, 7'd2, 12'h0AB, 32'h0,   0, 1, 6, 805,   967,   8};
      tbl[6] = '{8'd0,   7'd0,   8'd1, 7'd1, 12'hFFF, 32'h0,   0, 0, 1, 0,     0,     3};

      reset_n = 1'b0; cmd_valid = 1'b0; hold = 1'b0;
      cmd_x0 = '0; cmd_y0 = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;
      #1;
      chk("rst_ready", int'(cmd_ready), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_wren", int'(wren_ram), 0);
      chk("rst_addr", int'(address_ram), 0);
      chk("rst_data", int'(data_ram), 0);
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock); #1;

      for (int i = 0; i < 6; i++) run_tbl(tbl[i], $sformatf("tbl%0d", i));

      // Abort scenario 1 mid-fill with reset, then confirm a fresh command works.
      cmd_x0 = 8'd2; cmd_y0 = 7'd1; cmd_w = 8'd2; cmd_h = 7'd2; cmd_color = 12'hF00;
      cmd_valid = 1'b1;
      @(posedge clock); #1;
      cmd_valid = 1'b0;
      @(posedge clock); #1;
      @(negedge clock);
      chk("abort_first_wren", int'(wren_ram), 1);
      chk("abort_first_addr", int'(address_ram), 162);
      @(posedge clock); #1;
      reset_n = 1'b0;
      #1;
      chk("abort_wren", int'(wren_ram), 0);
      chk("abort_ready", int'(cmd_ready), 1);
      chk("abort_done", int'(done), 0);
      chk("abort_addr", int'(address_ram), 0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         chk("abort_nodone", int'(done), 0);
      end
      reset_n = 1'b1;
      @(negedge clock);
      chk("abort_idle_ready", int'(cmd_ready), 1);
      chk("abort_idle_done", int'(done), 0);
      @(posedge clock); #1;
      run_tbl(tbl[6], "post_reset");

      for (int i = 0; i < 40; i++) begin
         rv = tbl[0];
         rv.x0 = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(140, 255)) : 8'($urandom_range(0, 159));
         rv.y0 = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(110, 127)) : 7'($urandom_range(0, 119));
         rv.w = 8'($urandom_range(0, 12));
         rv.h = 7'($urandom_range(0, 6));
         rv.color = 12'($urandom_range(0, 4095));
         rv.rnd_hold = 1;
         rv.keep = ($urandom_range(0, 1) == 1);
         run_cmd(rv, nwr, fa, la, dc);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
